// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/gnt/rvalid handshake,
// and drives the IF/ID register through a one-entry skid buffer with redirect flushing.
module if_stage #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic                 inst_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                 state, state_next;
    logic [CPU_WIDTH-1:0]   fetch_pc, fetch_pc_next;
    logic                   kill, kill_next;
    logic [CPU_WIDTH-1:0]   req_pc;
    logic                   skid_full;
    logic [CPU_WIDTH-1:0]   skid_inst;
    logic [CPU_WIDTH-1:0]   skid_pc;
    logic [CPU_WIDTH-1:0]   redirect_aligned;
    logic                   gnt_ok;
    logic                   deliver;
    logic                   unused_pc_bits;

    // Fetch targets are always word aligned; the low redirect bits are dropped.
    assign redirect_aligned = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign unused_pc_bits   = ^redirect_pc[1:0];

    assign imem_req  = (state == S_REQ) && !skid_full && !stall;
    assign imem_addr = fetch_pc;
    assign gnt_ok    = imem_req && imem_gnt;
    // A response belonging to a killed or concurrently redirected fetch never reaches IF/ID.
    assign deliver   = (state == S_WAIT) && imem_rvalid && !kill && !redirect;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        kill_next     = kill;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (gnt_ok) begin
                    state_next = S_WAIT;
                    if (redirect) begin
                        fetch_pc_next = redirect_aligned;
                        kill_next     = 1'b1;
                    end else begin
                        fetch_pc_next = fetch_pc + CPU_WIDTH'(4);
                        kill_next     = 1'b0;
                    end
                end else if (redirect) begin
                    fetch_pc_next = redirect_aligned;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_next = redirect_aligned;
                end
                if (imem_rvalid) begin
                    state_next = S_REQ;
                    kill_next  = 1'b0;
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            kill     <= kill_next;
        end
    end

    // Datapath-only registers; their contents are meaningless until qualified by control.
    always_ff @(posedge clk) begin
        if (gnt_ok) begin
            req_pc <= fetch_pc;
        end
        if (!redirect && stall && deliver) begin
            skid_inst <= imem_rdata;
            skid_pc   <= req_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full  <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            skid_full  <= 1'b0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (stall) begin
            if (deliver) begin
                skid_full <= 1'b1;
            end
        end else if (skid_full) begin
            skid_full  <= 1'b0;
            inst       <= skid_inst;
            inst_pc    <= skid_pc;
            inst_valid <= 1'b1;
        end else if (deliver) begin
            inst       <= imem_rdata;
            inst_pc    <= req_pc;
            inst_valid <= 1'b1;
        end else begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end
    end

endmodule
